// File: rtl/demux_1ne8_seq_pkg.sv
// Shared constants and channel state type for the 1-to-8 sequential distributor.
package demux_1ne8_seq_pkg;
   localparam int DATA_W = 24;
   localparam int NCH    = 8;
   localparam int SEL_W  = 3;
   localparam int CNT_W  = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } chan_state_t;
endpackage

// File: rtl/demux_1ne8_seq_kanal_mbajtes.sv
// Single-channel holding slot: EMPTY/FULL state with a data register.
// A write in the same cycle as an ack wins, so the slot stays FULL.
module kanal_mbajtes
   import demux_1ne8_seq_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ack,
   output logic [WIDTH-1:0] data_out,
   output logic             valid
);

   chan_state_t state;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= EMPTY;
         data_out <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (wr_en) begin
                  state    <= FULL;
                  data_out <= data_in;
               end
            end
            FULL: begin
               if (wr_en) begin
                  data_out <= data_in;
               end else if (ack) begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign valid = (state == FULL);

endmodule

// File: rtl/demux_1ne8_seq.sv
// Sequential 1-to-8 distributor: steers each accepted word to a channel slot chosen
// by s or by a round-robin pointer. Optional stall counter under DEMUX_OVERFLOW_CNT_EN.
module demux_1ne8_seq
   import demux_1ne8_seq_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [WIDTH-1:0]     hyrja,
   input  logic                 hyrja_valid,
   output logic                 hyrja_ready,
   input  logic [SEL_W-1:0]     s,
   input  logic                 auto,
   output logic [NCH*WIDTH-1:0] dalja,
   output logic [NCH-1:0]       dalja_valid,
   input  logic [NCH-1:0]       dalja_ack,
   output logic [SEL_W-1:0]     ptr,
   output logic [CNT_W-1:0]     gabim_cnt
);

   logic [SEL_W-1:0] tgt;
   logic             accept;
   logic [NCH-1:0]   wr_en;

   assign tgt         = auto ? ptr : s;
   // No path from hyrja_valid into ready; the async reset forces it low directly.
   assign hyrja_ready = reset_n & (~dalja_valid[tgt] | dalja_ack[tgt]);
   assign accept      = hyrja_valid & hyrja_ready;

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      assign wr_en[k] = accept & (tgt == SEL_W'(k));

      kanal_mbajtes #(.WIDTH(WIDTH)) u_slot (
         .clock   (clock),
         .reset_n (reset_n),
         .wr_en   (wr_en[k]),
         .data_in (hyrja),
         .ack     (dalja_ack[k]),
         .data_out(dalja[k*WIDTH +: WIDTH]),
         .valid   (dalja_valid[k])
      );
   end

   // Strict order: the pointer only moves past a channel once it has accepted a word.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (accept && auto) begin
         ptr <= ptr + 1'b1;
      end
   end

`ifdef DEMUX_OVERFLOW_CNT_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         gabim_cnt <= '0;
      end else if (hyrja_valid && !hyrja_ready) begin
         gabim_cnt <= sat_inc(gabim_cnt);
      end
   end
`else
   assign gabim_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_1ne8_seq.sv
// Scoreboard bench for demux_1ne8_seq: directed stimulus pushes expected channel writes,
// a negedge monitor pops them as new words appear on the channel outputs.
module tb_demux_1ne8_seq;
   localparam int W = 24;

   logic            clock = 1'b0;
   logic            reset_n;
   logic [W-1:0]    hyrja;
   logic            hyrja_valid;
   logic            hyrja_ready;
   logic [2:0]      s;
   logic            auto;
   logic [8*W-1:0]  dalja;
   logic [7:0]      dalja_valid;
   logic [7:0]      dalja_ack;
   logic [2:0]      ptr;
   logic [7:0]      gabim_cnt;

   typedef struct {
      int          ch;
      logic [W-1:0] d;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   logic [7:0]   prev_valid = '0;
   logic [W-1:0] prev_data [8];

   demux_1ne8_seq dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .hyrja      (hyrja),
      .hyrja_valid(hyrja_valid),
      .hyrja_ready(hyrja_ready),
      .s          (s),
      .auto       (auto),
      .dalja      (dalja),
      .dalja_valid(dalja_valid),
      .dalja_ack  (dalja_ack),
      .ptr        (ptr),
      .gabim_cnt  (gabim_cnt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   function automatic logic [W-1:0] chan(input int k);
      return dalja[k*W +: W];
   endfunction

   task automatic push(input int ch, input logic [W-1:0] d);
      exp_t e;
      e.ch = ch;
      e.d  = d;
      exp_q.push_back(e);
   endtask

   // Monitor: a new word on channel k is valid rising, or fresh data under a held valid.
   initial for (int k = 0; k < 8; k++) prev_data[k] = '0;

   always @(negedge clock) begin
      for (int k = 0; k < 8; k++) begin
         if (dalja_valid[k] && (!prev_valid[k] || prev_data[k] !== chan(k))) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_write: ch %0d data %0h, none expected", k, chan(k));
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (e.ch != k || e.d !== chan(k)) begin
                  failures++;
                  $display("FAIL sb_write: got ch %0d data %0h expected ch %0d data %0h",
                           k, chan(k), e.ch, e.d);
               end
            end
         end
         prev_data[k] = chan(k);
      end
      prev_valid = dalja_valid;
   end

   initial begin
      logic [7:0] exp_cnt;
      reset_n     = 1'b0;
      hyrja       = '0;
      hyrja_valid = 1'b0;
      s           = '0;
      auto        = 1'b0;
      dalja_ack   = '0;

      // Reset state
      #3;
      chk("rst_valid", dalja_valid, 8'h00);
      chk("rst_ptr", ptr, 3'd0);
      chk("rst_ready", hyrja_ready, 1'b0);
      chk("rst_cnt", gabim_cnt, 8'h00);
      chk("rst_data_or", |dalja, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      tick();

      // Manual accept into channel 5, then ack
      auto = 1'b0; s = 3'd5; hyrja = 24'hABCDEF; hyrja_valid = 1'b1;
      #1 chk("man_ready", hyrja_ready, 1'b1);
      push(5, 24'hABCDEF);
      tick();
      hyrja_valid = 1'b0;
      chk("man_valid", dalja_valid, 8'b0010_0000);
      chk("man_ch5", chan(5), 24'hABCDEF);
      chk("man_ptr", ptr, 3'd0);
      dalja_ack = 8'h20;
      tick();
      dalja_ack = '0;
      chk("ack_valid", dalja_valid, 8'h00);
      chk("ack_ch5_hold", chan(5), 24'hABCDEF);

      // Round-robin fill of all 8 channels
      auto = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         hyrja = W'(i); hyrja_valid = 1'b1;
         #1 chk("rr_ready", hyrja_ready, 1'b1);
         push(i - 1, W'(i));
         tick();
      end
      chk("rr_ptr_wrap", ptr, 3'd0);
      chk("rr_all_full", dalja_valid, 8'hFF);
      hyrja = 24'h000009;
      for (int i = 0; i < 3; i++) begin
         #1 chk("rr_stall", hyrja_ready, 1'b0);
         tick();
      end
      chk("rr_stall_ptr", ptr, 3'd0);
      chk("rr_stall_ch0", chan(0), 24'h000001);
      dalja_ack = 8'h01;
      #1 chk("rr_unstall", hyrja_ready, 1'b1);
      push(0, 24'h000009);
      tick();
      dalja_ack = '0; hyrja_valid = 1'b0;
      chk("rr_ptr1", ptr, 3'd1);
      chk("rr_ch0", chan(0), 24'h000009);
      chk("rr_full2", dalja_valid, 8'hFF);

      // Full throughput on channel 2 (already full)
      auto = 1'b0; s = 3'd2; dalja_ack = 8'h04; hyrja_valid = 1'b1;
      for (int w = 'h10; w <= 'h13; w++) begin
         hyrja = W'(w);
         #1 chk("thr_ready", hyrja_ready, 1'b1);
         push(2, W'(w));
         tick();
         chk("thr_valid2", dalja_valid[2], 1'b1);
      end
      hyrja_valid = 1'b0; dalja_ack = '0;
      chk("thr_ch2", chan(2), 24'h000013);
      dalja_ack = 8'hFF;
      tick();
      dalja_ack = '0;
      chk("drain_valid", dalja_valid, 8'h00);

      // Stray acks on empty channels
      dalja_ack = 8'hFF;
      tick();
      tick();
      dalja_ack = '0;
      chk("stray_valid", dalja_valid, 8'h00);
      chk("stray_ptr", ptr, 3'd1);

      // Overflow stall: fill channel 6 then hold valid for 300 cycles
      s = 3'd6; hyrja = 24'h0000C6; hyrja_valid = 1'b1;
      push(6, 24'h0000C6);
      tick();
      hyrja = 24'h0000FE;
      #1 chk("ovf_ready", hyrja_ready, 1'b0);
      repeat (300) tick();
      hyrja_valid = 1'b0;
`ifdef DEMUX_OVERFLOW_CNT_EN
      exp_cnt = 8'hFF;
`else
      exp_cnt = 8'h00;
`endif
      chk("ovf_cnt", gabim_cnt, exp_cnt);
      chk("ovf_ch6", chan(6), 24'h0000C6);
      dalja_ack = 8'h40;
      tick();
      dalja_ack = '0;

      // Build channels 0,3 full with ptr=4, then async reset mid-cycle
      auto = 1'b1; hyrja_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         hyrja = W'(32'h30 + i);
         push(i, W'(32'h30 + i));
         tick();
      end
      hyrja_valid = 1'b0;
      chk("pre_ptr4", ptr, 3'd4);
      dalja_ack = 8'h06;
      tick();
      dalja_ack = '0;
      auto = 1'b0; s = 3'd0; hyrja = 24'h0000A0; hyrja_valid = 1'b1;
      push(0, 24'h0000A0);
      tick();
      hyrja_valid = 1'b0;
      chk("pre_valid", dalja_valid, 8'b0000_1001);
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_valid", dalja_valid, 8'h00);
      chk("arst_ptr", ptr, 3'd0);
      chk("arst_ready", hyrja_ready, 1'b0);
      chk("arst_cnt", gabim_cnt, 8'h00);
      @(negedge clock);
      tick();
      chk("sb_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/demux_1ne8_seq.md
Name: demux_1ne8_seq

Overview:
- Sequential 1-to-8 distributor: the inverse of the datapath 8-to-1 select muxes.
- Accepts one WIDTH-bit word per handshake and steers it into one of 8 per-channel holding registers.
- The target is chosen by an explicit 3-bit select or by an internal round-robin pointer.
- Sits between the 24-bit write-back path and consumers that need words fanned out (register-bank write staging, peripheral channels).

Parameters:
- WIDTH, 24, data word width in bits.
- NCH, 8, number of output channels; fixed at 8 because S is 3 bits.

Ports:
- Clock  input  1  single system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Hyrja  input  WIDTH  input data word.
- Hyrja_valid  input  1  input word present.
- Hyrja_ready  output  1  block can accept this cycle.
- S  input  3  target channel in manual mode (000 selects channel 0 … 111 selects channel 7).
- Auto  input  1  1 selects round-robin pointer, 0 selects S.
- Dalja  output  8*WIDTH  channel k data on bits [k*WIDTH +: WIDTH].
- Dalja_valid  output  8  per-channel word-held flag.
- Dalja_ack  input  8  per-channel consume strobe.
- Ptr  output  3  current round-robin pointer.
- Gabim_cnt  output  8  overflow-stall counter (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on Reset_n.
- Reset values (while Reset_n=0):
  - all Dalja registers = 0; Dalja_valid = 8'h00; Ptr = 3'd0; Gabim_cnt = 0.
  - Hyrja_ready = 0, forced combinationally.
- Target selection (combinational): tgt = Auto ? Ptr : S. Auto and S are sampled every cycle.
- Hyrja_ready = Reset_n & (!Dalja_valid[tgt] | Dalja_ack[tgt]). This is a combinational path from Dalja_ack, Auto and S; there is no path from Hyrja_valid.
- Accept: Hyrja_valid & Hyrja_ready at a rising edge.
  - Dalja[tgt] <= Hyrja and Dalja_valid[tgt] <= 1.
  - Data is visible on the outputs 1 cycle after the accept edge.
- Ack: Dalja_ack[k] & Dalja_valid[k] clears Dalja_valid[k] at the edge. Dalja data is not cleared; it holds its last value.
  - Ack on an empty channel is ignored.
  - Acks on multiple channels in the same cycle are all honoured.
- Simultaneous accept and ack on the same channel: the new word is written and Dalja_valid[k] stays 1. This is the full-throughput case, 1 word per cycle per channel.
- Round-robin pointer:
  - In Auto=1, Ptr increments by 1 on each accept and wraps 7→0.
  - Ptr holds when there is no accept, and holds in Auto=0.
  - Toggling Auto does not reset Ptr.
- Channel state machine (per channel): EMPTY → FULL on accept; FULL → EMPTY on ack without accept; FULL → FULL on accept+ack.
- Stall: in auto mode the block never skips a full channel. It waits at Ptr until that channel is acked (strict order).
- Reset mid-operation: all held words are discarded immediately (async) and Ptr returns to 0. An in-flight handshake in the reset cycle is lost.

Optional Feature:
- Macro: DEMUX_OVERFLOW_CNT_EN.
- Defined:
  - Gabim_cnt is an 8-bit counter incremented each cycle with Hyrja_valid & !Hyrja_ready.
  - It saturates at 8'hFF and is cleared only by reset.
- Not defined:
  - Gabim_cnt is tied to 8'h00 and no counter flops are synthesised.
  - The port list is identical in both builds.

Decomposition:
- Shared package holds constants DATA_W=24, NCH=8, SEL_W=3, CNT_W=8.
- Natural sub-module: kanal_mbajtes, a single-channel holding slot.
  - Inputs: Clock, Reset_n, wr_en, data_in, ack. Outputs: data_out, valid.
  - Implements the EMPTY/FULL state machine and accept-plus-ack priority.
  - Instantiated 8 times via generate.
- The top level owns tgt decode, Hyrja_ready, Ptr and Gabim_cnt.

Test Plan:
- Reset, manual accept, ack:
  - Reset, then Auto=0, S=3'b101, Hyrja=24'hABCDEF, valid 1 cycle → next cycle Dalja_valid=8'b0010_0000 and channel 5 = 24'hABCDEF, Ptr=0.
  - Then Dalja_ack[5]=1 for one cycle → Dalja_valid=0 and channel 5 still reads 24'hABCDEF.
- Round-robin fill: Auto=1, 9 consecutive valid words 24'h000001…24'h000009, no acks.
  - The first 8 are accepted into channels 0–7 and Ptr wraps to 0.
  - The 9th stalls (Hyrja_ready=0) until Dalja_ack[0] is pulsed; it then lands in channel 0 and Ptr=1.
- Full throughput: channel 2 full, S=2, Hyrja_valid=1 and Dalja_ack[2]=1 held for 4 cycles with words 24'h10–24'h13.
  - Hyrja_ready=1 every cycle, Dalja_valid[2] stays 1, channel 2 reads 24'h13 at the end.
- Stray ack: Dalja_ack=8'hFF while all channels are empty → no state change and Dalja_valid stays 0.
- Async reset: Reset_n low mid-cycle with channels 0 and 3 full and Ptr=4 → immediately Dalja_valid=0, Ptr=0, Hyrja_ready=0, without waiting for a clock edge.
- Overflow counter (DEMUX_OVERFLOW_CNT_EN defined):
  - 300 stalled cycles → Gabim_cnt=8'hFF.
  - With the macro undefined, the same stimulus gives Gabim_cnt=0.
